// File: rtl/uart_serial_bfm_if.sv
// Handshake and receive-result bundle for uart_serial_bfm.
// master = environment / requester side, slave = the UART endpoint.
interface uart_serial_bfm_if;
    logic       tx_start;
    logic [7:0] tx_data;
    logic       tx_busy;
    logic       tx_clear_req;
    logic [7:0] recv_pattern;
    logic       recv_valid;
    logic       recv_frame_err;

    modport master (
        output tx_start, tx_data,
        input  tx_busy, tx_clear_req, recv_pattern, recv_valid, recv_frame_err
    );

    modport slave (
        input  tx_start, tx_data,
        output tx_busy, tx_clear_req, recv_pattern, recv_valid, recv_frame_err
    );
endinterface

// File: rtl/uart_serial_bfm.sv
// Full-duplex 8N1 UART endpoint (independent TX and RX in one clock domain).
// Define UART_PARITY_EN to insert and check an even-parity bit after data bit 7.
module uart_serial_bfm #(
    parameter int CLKS_PER_BIT = 4167,
    parameter int SYNC_STAGES  = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             ser_rx,
    output logic             ser_tx,
    uart_serial_bfm_if.slave bus
);
    localparam int            CW       = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] BIT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] BIT_MID  = CW'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [2:0] {
        TX_IDLE, TX_START, TX_DATA,
`ifdef UART_PARITY_EN
        TX_PARITY,
`endif
        TX_STOP, TX_DONE
    } tx_state_t;

    typedef enum logic [2:0] {
        RX_IDLE, RX_START, RX_DATA,
`ifdef UART_PARITY_EN
        RX_PARITY,
`endif
        RX_STOP, RX_WAIT_HIGH
    } rx_state_t;

    tx_state_t       tx_state, tx_next;
    logic [CW-1:0]   tx_cnt;
    logic [2:0]      tx_bit_idx, tx_bit_next;
    logic [7:0]      tx_shift;
    logic            tx_tick;
    logic            tx_clear_req_q, tx_busy_q, ser_tx_q;
    logic            tx_busy_d, ser_tx_d;

    assign tx_tick          = (tx_cnt == BIT_LAST);
    assign ser_tx           = ser_tx_q;
    assign bus.tx_busy      = tx_busy_q;
    assign bus.tx_clear_req = tx_clear_req_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) tx_state <= TX_IDLE;
        else       tx_state <= tx_next;
    end

    always_comb begin
        tx_next = tx_state;
        unique case (tx_state)
            TX_IDLE:   if (bus.tx_start && !tx_clear_req_q) tx_next = TX_START;
            TX_START:  if (tx_tick) tx_next = TX_DATA;
`ifdef UART_PARITY_EN
            TX_DATA:   if (tx_tick && tx_bit_idx == 3'd7) tx_next = TX_PARITY;
            TX_PARITY: if (tx_tick) tx_next = TX_STOP;
`else
            TX_DATA:   if (tx_tick && tx_bit_idx == 3'd7) tx_next = TX_STOP;
`endif
            TX_STOP:   if (tx_tick) tx_next = TX_DONE;
            TX_DONE:   tx_next = TX_IDLE;
            default:   tx_next = TX_IDLE;
        endcase
    end

    // Outputs are decoded from the next state and registered, so ser_tx never glitches.
    always_comb begin
        tx_bit_next = (tx_state == TX_DATA && tx_tick) ? tx_bit_idx + 3'd1 : tx_bit_idx;
        ser_tx_d    = 1'b1;
        tx_busy_d   = 1'b1;
        unique case (tx_next)
            TX_IDLE, TX_DONE: tx_busy_d = 1'b0;
            TX_START:         ser_tx_d  = 1'b0;
            TX_DATA:          ser_tx_d  = tx_shift[tx_bit_next];
`ifdef UART_PARITY_EN
            TX_PARITY:        ser_tx_d  = ^tx_shift;
`endif
            default:          ser_tx_d  = 1'b1;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ser_tx_q       <= 1'b1;
            tx_busy_q      <= 1'b0;
            tx_clear_req_q <= 1'b0;
            tx_cnt         <= '0;
            tx_bit_idx     <= '0;
            tx_shift       <= '0;
        end else begin
            ser_tx_q  <= ser_tx_d;
            tx_busy_q <= tx_busy_d;
            if (tx_state == TX_IDLE) begin
                tx_cnt     <= '0;
                tx_bit_idx <= '0;
                if (tx_next == TX_START) tx_shift <= bus.tx_data;
            end else begin
                tx_cnt <= tx_tick ? '0 : tx_cnt + 1'b1;
                if (tx_state == TX_DATA && tx_tick) tx_bit_idx <= tx_bit_idx + 3'd1;
            end
            // Disarmed from frame end until the requester is seen dropping tx_start.
            if (tx_next == TX_DONE)                       tx_clear_req_q <= 1'b1;
            else if (tx_clear_req_q && !bus.tx_start)     tx_clear_req_q <= 1'b0;
        end
    end

    rx_state_t            rx_state, rx_next;
    logic [SYNC_STAGES-1:0] rx_sync;
    logic                 rx_s;
    logic [CW-1:0]        rx_cnt;
    logic [2:0]           rx_bit_idx;
    logic [7:0]           rx_shift;
    logic                 rx_mid, rx_tick;
    logic                 rx_valid_d, rx_err_d;
    logic                 recv_valid_q, recv_err_q;
    logic [7:0]           recv_pattern_q;
`ifdef UART_PARITY_EN
    logic                 rx_parity_ok;
`endif

    assign rx_s               = rx_sync[SYNC_STAGES-1];
    assign rx_mid             = (rx_cnt == BIT_MID);
    assign rx_tick            = (rx_cnt == BIT_LAST);
    assign bus.recv_pattern   = recv_pattern_q;
    assign bus.recv_valid     = recv_valid_q;
    assign bus.recv_frame_err = recv_err_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rx_state <= RX_IDLE;
            rx_sync  <= '1;
        end else begin
            rx_state <= rx_next;
            rx_sync  <= (rx_sync << 1) | SYNC_STAGES'(ser_rx);
        end
    end

    always_comb begin
        rx_next = rx_state;
        unique case (rx_state)
            RX_IDLE:      if (!rx_s) rx_next = RX_START;
            RX_START:     if (rx_mid) rx_next = rx_s ? RX_IDLE : RX_DATA;
`ifdef UART_PARITY_EN
            RX_DATA:      if (rx_tick && rx_bit_idx == 3'd7) rx_next = RX_PARITY;
            RX_PARITY:    if (rx_tick) rx_next = RX_STOP;
`else
            RX_DATA:      if (rx_tick && rx_bit_idx == 3'd7) rx_next = RX_STOP;
`endif
            RX_STOP:      if (rx_tick) rx_next = rx_s ? RX_IDLE : RX_WAIT_HIGH;
            RX_WAIT_HIGH: if (rx_s) rx_next = RX_IDLE;
            default:      rx_next = RX_IDLE;
        endcase
    end

    always_comb begin
        rx_valid_d = 1'b0;
        rx_err_d   = 1'b0;
        if (rx_state == RX_STOP && rx_tick) begin
`ifdef UART_PARITY_EN
            if (rx_s && rx_parity_ok) rx_valid_d = 1'b1;
            else                      rx_err_d   = 1'b1;
`else
            if (rx_s) rx_valid_d = 1'b1;
            else      rx_err_d   = 1'b1;
`endif
        end
    end

    // Counter restarts at the start-bit centre so later samples land mid-bit.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rx_cnt         <= '0;
            rx_bit_idx     <= '0;
            rx_shift       <= '0;
            recv_valid_q   <= 1'b0;
            recv_err_q     <= 1'b0;
            recv_pattern_q <= '0;
`ifdef UART_PARITY_EN
            rx_parity_ok   <= 1'b0;
`endif
        end else begin
            recv_valid_q <= rx_valid_d;
            recv_err_q   <= rx_err_d;
            if (rx_valid_d) recv_pattern_q <= rx_shift;
            if (rx_state == RX_IDLE || rx_state == RX_WAIT_HIGH ||
                (rx_state == RX_START && rx_mid) || rx_tick)
                rx_cnt <= '0;
            else
                rx_cnt <= rx_cnt + 1'b1;
            if (rx_state == RX_IDLE) rx_bit_idx <= '0;
            if (rx_state == RX_DATA && rx_tick) begin
                rx_shift   <= {rx_s, rx_shift[7:1]};
                rx_bit_idx <= rx_bit_idx + 3'd1;
            end
`ifdef UART_PARITY_EN
            if (rx_state == RX_PARITY && rx_tick) rx_parity_ok <= ((^rx_shift) == rx_s);
`endif
        end
    end
endmodule

// File: tb/tb_uart_serial_bfm.sv
// Randomised self-checking bench for uart_serial_bfm with a frame-level reference model.
// Follows UART_PARITY_EN so the model frame matches the build.
module tb_uart_serial_bfm;
    localparam int CPB = 16;
`ifdef UART_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic drive_rx = 1'b1;
    logic loopback = 1'b0;
    logic ser_rx, ser_tx;

    uart_serial_bfm_if bus();

    assign ser_rx = loopback ? ser_tx : drive_rx;

    uart_serial_bfm #(.CLKS_PER_BIT(CPB), .SYNC_STAGES(2)) dut (
        .clock  (clock),
        .reset  (reset),
        .ser_rx (ser_rx),
        .ser_tx (ser_tx),
        .bus    (bus)
    );

    always #5 clock = ~clock;

    int         n_cmp = 0;
    int         n_fail = 0;
    int         valid_cycles = 0;
    int         err_cycles = 0;
    logic [7:0] got_q[$];
    logic [7:0] exp_last = 8'h00;

    always @(negedge clock) begin
        if (!reset) begin
            if (bus.recv_valid) begin
                valid_cycles++;
                got_q.push_back(bus.recv_pattern);
            end
            if (bus.recv_frame_err) err_cycles++;
        end
    end

    // Serial frame as transmitted, bit 0 first; unused high bit is idle line.
    function automatic logic [10:0] frame_of(input logic [7:0] d);
`ifdef UART_PARITY_EN
        return {1'b1, ^d, d, 1'b0};
`else
        return {2'b11, d, 1'b0};
`endif
    endfunction

    task automatic idle_cycles(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic drive_rx_frame(input logic [7:0] d, input logic [10:0] flip);
        logic [10:0] f;
        f = frame_of(d) ^ flip;
        for (int b = 0; b < NB; b++)
            for (int c = 0; c < CPB; c++) begin
                @(negedge clock);
                drive_rx = f[b];
            end
    endtask

    task automatic capture_tx_frame(input logic [7:0] d, output logic [10:0] bits,
                                    output logic busy_first, output logic clear_after,
                                    output logic timeout);
        @(negedge clock);
        bus.tx_data  = d;
        bus.tx_start = 1'b1;
        bits = '1;
        busy_first = 1'b0;
        for (int j = 0; j < NB * CPB; j++) begin
            @(negedge clock);
            if (j == 0) busy_first = bus.tx_busy;
            if (j % CPB == CPB / 2) bits[j / CPB] = ser_tx;
        end
        @(negedge clock);
        clear_after  = bus.tx_clear_req;
        bus.tx_start = 1'b0;
        timeout = 1'b1;
        for (int k = 0; k < 50; k++) begin
            @(negedge clock);
            if (!bus.tx_clear_req) begin
                timeout = 1'b0;
                break;
            end
        end
    endtask

    task automatic test_reset;
        logic [12:0] obs;
        idle_cycles(3);
        obs = {ser_tx, bus.tx_busy, bus.tx_clear_req, bus.recv_valid, bus.recv_frame_err, bus.recv_pattern};
        n_cmp++;
        if (obs !== {5'b10000, 8'h00}) begin
            n_fail++;
            $display("[TB] FAIL reset_held: got %b expected %b", obs, {5'b10000, 8'h00});
        end
        reset = 1'b0;
        idle_cycles(2);
        obs = {ser_tx, bus.tx_busy, bus.tx_clear_req, bus.recv_valid, bus.recv_frame_err, bus.recv_pattern};
        n_cmp++;
        if (obs !== {5'b10000, 8'h00}) begin
            n_fail++;
            $display("[TB] FAIL reset_released: got %b expected %b", obs, {5'b10000, 8'h00});
        end
    endtask

    task automatic test_tx_timing;
        logic [10:0] f, bit_bad;
        logic        busy_bad, hold_bad;
        f = frame_of(8'h3D);
        bit_bad = '0;
        busy_bad = 1'b0;
        hold_bad = 1'b0;
        @(negedge clock);
        bus.tx_data  = 8'h3D;
        bus.tx_start = 1'b1;
        for (int j = 0; j < NB * CPB; j++) begin
            @(negedge clock);
            if (ser_tx !== f[j / CPB]) bit_bad[j / CPB] = 1'b1;
            if (bus.tx_busy !== 1'b1) busy_bad = 1'b1;
        end
        for (int b = 0; b < NB; b++) begin
            n_cmp++;
            if (bit_bad[b]) begin
                n_fail++;
                $display("[TB] FAIL tx_bit%0d: line differed from required %b during the bit", b, f[b]);
            end
        end
        n_cmp++;
        if (busy_bad) begin
            n_fail++;
            $display("[TB] FAIL tx_busy_frame: busy dropped, required 1 for the whole frame");
        end
        @(negedge clock);
        n_cmp++;
        if ({bus.tx_busy, bus.tx_clear_req} !== 2'b01) begin
            n_fail++;
            $display("[TB] FAIL tx_done: busy/clear got %b%b expected 01", bus.tx_busy, bus.tx_clear_req);
        end
        for (int k = 0; k < 5; k++) begin
            @(negedge clock);
            if (bus.tx_busy !== 1'b0 || ser_tx !== 1'b1 || bus.tx_clear_req !== 1'b1) hold_bad = 1'b1;
        end
        n_cmp++;
        if (hold_bad) begin
            n_fail++;
            $display("[TB] FAIL tx_hold: new frame or clear lost, required busy=0 ser_tx=1 clear=1");
        end
        bus.tx_start = 1'b0;
        @(negedge clock);
        n_cmp++;
        if (bus.tx_clear_req !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL tx_clear_drop: got %b expected 0", bus.tx_clear_req);
        end
    endtask

    task automatic test_handshake_rearm;
        logic [10:0] bits;
        logic        busy_first, clear_after, timeout;
        logic [7:0]  d;
        for (int i = 0; i < 3; i++) begin
            d = (i == 0) ? 8'h0F : 8'($urandom_range(255, 0));
            capture_tx_frame(d, bits, busy_first, clear_after, timeout);
            n_cmp++;
            if (bits !== frame_of(d)) begin
                n_fail++;
                $display("[TB] FAIL tx_frame_%02h: got %b expected %b", d, bits, frame_of(d));
            end
            n_cmp++;
            if ({busy_first, clear_after, timeout} !== 3'b110) begin
                n_fail++;
                $display("[TB] FAIL tx_handshake_%02h: busy/clear/timeout got %b expected 110",
                         d, {busy_first, clear_after, timeout});
            end
        end
    endtask

    task automatic test_rx_good;
        int         v0, e0;
        logic [7:0] d;
        for (int i = 0; i < 5; i++) begin
            d = (i == 0) ? 8'h0F : (i == 1) ? 8'h3D : 8'($urandom_range(255, 0));
            v0 = valid_cycles;
            e0 = err_cycles;
            drive_rx_frame(d, 11'd0);
            idle_cycles(6);
            exp_last = d;
            n_cmp++;
            if (valid_cycles - v0 != 1 || err_cycles != e0) begin
                n_fail++;
                $display("[TB] FAIL rx_pulse_%02h: valid cycles %0d err cycles %0d, required 1 and 0",
                         d, valid_cycles - v0, err_cycles - e0);
            end
            n_cmp++;
            if (bus.recv_pattern !== exp_last) begin
                n_fail++;
                $display("[TB] FAIL rx_pattern: got %02h expected %02h", bus.recv_pattern, exp_last);
            end
        end
    endtask

    task automatic test_rx_errors;
        int         v0, e0;
        logic [7:0] d;
        v0 = valid_cycles;
        e0 = err_cycles;
        @(negedge clock);
        drive_rx = 1'b0;
        idle_cycles(4);
        drive_rx = 1'b1;
        idle_cycles(40);
        n_cmp++;
        if (valid_cycles != v0 || err_cycles != e0) begin
            n_fail++;
            $display("[TB] FAIL rx_glitch: valid %0d err %0d pulses, required 0 and 0",
                     valid_cycles - v0, err_cycles - e0);
        end
        drive_rx_frame(8'hA5, 11'(1 << (NB - 1)));
        @(negedge clock);
        drive_rx = 1'b1;
        idle_cycles(20);
        n_cmp++;
        if (err_cycles - e0 != 1 || valid_cycles != v0) begin
            n_fail++;
            $display("[TB] FAIL rx_bad_stop: err %0d valid %0d, required 1 and 0",
                     err_cycles - e0, valid_cycles - v0);
        end
        n_cmp++;
        if (bus.recv_pattern !== exp_last) begin
            n_fail++;
            $display("[TB] FAIL rx_bad_stop_pattern: got %02h expected %02h", bus.recv_pattern, exp_last);
        end
`ifdef UART_PARITY_EN
        e0 = err_cycles;
        drive_rx_frame(8'h3C, 11'(1 << 9));
        idle_cycles(6);
        n_cmp++;
        if (err_cycles - e0 != 1 || valid_cycles != v0 || bus.recv_pattern !== exp_last) begin
            n_fail++;
            $display("[TB] FAIL rx_bad_parity: err %0d valid %0d pattern %02h, required 1 0 %02h",
                     err_cycles - e0, valid_cycles - v0, bus.recv_pattern, exp_last);
        end
`endif
        d = 8'($urandom_range(255, 0));
        drive_rx_frame(d, 11'd0);
        idle_cycles(6);
        exp_last = d;
        n_cmp++;
        if (bus.recv_pattern !== exp_last || valid_cycles - v0 != 1) begin
            n_fail++;
            $display("[TB] FAIL rx_recover: got %02h (%0d pulses) expected %02h (1 pulse)",
                     bus.recv_pattern, valid_cycles - v0, exp_last);
        end
    endtask

    task automatic test_back_to_back;
        logic [7:0] exp_q[$];
        int         base, waited;
        base = got_q.size();
        exp_q = {};
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(8'($urandom_range(255, 0)));
            drive_rx_frame(exp_q[i], 11'd0);
        end
        idle_cycles(6);
        exp_q.push_back(8'h00);
        exp_q.push_back(8'hFF);
        exp_q.push_back(8'h55);
        loopback = 1'b1;
        for (int i = 4; i < 7; i++) begin
            @(negedge clock);
            bus.tx_data  = exp_q[i];
            bus.tx_start = 1'b1;
            waited = 0;
            while (!bus.tx_clear_req && waited < 400) begin
                @(negedge clock);
                waited++;
            end
            bus.tx_start = 1'b0;
            while (bus.tx_clear_req && waited < 450) begin
                @(negedge clock);
                waited++;
            end
            n_cmp++;
            if (waited >= 400) begin
                n_fail++;
                $display("[TB] FAIL loop_handshake_%0d: waited %0d cycles, required under 400", i, waited);
            end
        end
        idle_cycles(40);
        loopback = 1'b0;
        n_cmp++;
        if (got_q.size() - base != exp_q.size()) begin
            n_fail++;
            $display("[TB] FAIL b2b_count: got %0d bytes expected %0d", got_q.size() - base, exp_q.size());
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            n_cmp++;
            if (base + i >= got_q.size()) begin
                n_fail++;
                $display("[TB] FAIL b2b_byte%0d: got nothing expected %02h", i, exp_q[i]);
            end else if (got_q[base + i] !== exp_q[i]) begin
                n_fail++;
                $display("[TB] FAIL b2b_byte%0d: got %02h expected %02h", i, got_q[base + i], exp_q[i]);
            end
        end
        exp_last = exp_q[exp_q.size() - 1];
    endtask

    task automatic test_reset_mid_frame;
        logic [10:0] bits;
        logic        busy_first, clear_after, timeout;
        logic [7:0]  d;
        @(negedge clock);
        bus.tx_data  = 8'($urandom_range(255, 0));
        bus.tx_start = 1'b1;
        idle_cycles(CPB + 3 * CPB + CPB / 4);
        reset = 1'b1;
        #1;
        n_cmp++;
        if ({ser_tx, bus.tx_busy, bus.tx_clear_req} !== 3'b100 || bus.recv_pattern !== 8'h00) begin
            n_fail++;
            $display("[TB] FAIL reset_mid_frame: ser_tx/busy/clear %b pattern %02h, required 100 and 00",
                     {ser_tx, bus.tx_busy, bus.tx_clear_req}, bus.recv_pattern);
        end
        bus.tx_start = 1'b0;
        idle_cycles(3);
        reset = 1'b0;
        exp_last = 8'h00;
        idle_cycles(2);
        d = 8'($urandom_range(255, 0));
        capture_tx_frame(d, bits, busy_first, clear_after, timeout);
        n_cmp++;
        if (bits !== frame_of(d) || {busy_first, clear_after, timeout} !== 3'b110) begin
            n_fail++;
            $display("[TB] FAIL post_reset_frame: got %b (%b) expected %b (110)",
                     bits, {busy_first, clear_after, timeout}, frame_of(d));
        end
    endtask

    initial begin
        bus.tx_start = 1'b0;
        bus.tx_data  = 8'h00;
        test_reset();
        test_tx_timing();
        test_handshake_rearm();
        test_rx_good();
        test_rx_errors();
        test_back_to_back();
        test_reset_mid_frame();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached before completion");
        $fatal(1, "[TB] watchdog expired");
    end
endmodule

// File: doc/uart_serial_bfm.md
Name: uart_serial_bfm

Overview:
- Full-duplex 8N1 UART endpoint: one serial transmitter and one serial receiver in a single clock domain.
- Placed outside the SoC and connected to its UART pins. ser_tx drives the chip's RX pin; ser_rx observes the chip's TX pin.
- Transmit uses a level-start / busy / clear-request handshake.
- Received bytes are exposed on recv_pattern so the environment can compare them directly.

Parameters:
- CLKS_PER_BIT, default 4167: clock cycles per serial bit; 40 MHz / 9600 baud. Must be ≥ 4.
- SYNC_STAGES, default 2: flip-flop stages in the ser_rx synchroniser.

Ports:
- clock  in  1  system clock, rising-edge active
- reset  in  1  asynchronous reset, active-high
- ser_rx  in  1  serial input, idle high
- ser_tx  out  1  serial output, idle high
- tx_start  in  1  level request to send tx_data
- tx_data  in  8  byte to transmit; sampled at start acceptance
- tx_busy  out  1  transmitter is sending a frame
- tx_clear_req  out  1  frame done; requester must drop tx_start
- recv_pattern  out  8  last correctly framed received byte
- recv_valid  out  1  one-cycle pulse when recv_pattern updates
- recv_frame_err  out  1  one-cycle pulse on bad stop bit

Behaviour:
- Reset (asynchronous, all outputs):
  - ser_tx=1; tx_busy=0; tx_clear_req=0.
  - recv_pattern=0x00; recv_valid=0; recv_frame_err=0.
  - Both FSMs go to IDLE; transmitter becomes armed.
  - Reset asserted mid-frame forces ser_tx high immediately, with no glitch low.
- Frame format: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1). Every bit lasts exactly CLKS_PER_BIT cycles.
- TX FSM, states IDLE → START → DATA → STOP → DONE:
  - IDLE: a start is accepted on the cycle where tx_start=1 and the transmitter is armed. tx_data is latched on that edge.
  - Next cycle: tx_busy=1 and ser_tx=0; the START state begins.
  - DATA: shifts out 8 bits using a 3-bit bit index.
  - STOP: drives ser_tx=1 for CLKS_PER_BIT cycles.
  - DONE, first cycle after STOP: tx_busy=0; tx_clear_req=1; transmitter becomes disarmed; FSM returns to IDLE.
  - tx_clear_req holds until tx_start is sampled low. It clears in the cycle after tx_start is seen low; the transmitter is then rearmed.
  - tx_start held high across a frame end never starts a second frame.
  - tx_data and tx_start changes during a frame are ignored.
- RX FSM, states IDLE → START → DATA → STOP → WAIT_HIGH:
  - ser_rx passes through SYNC_STAGES flip-flops before use; resets to 1.
  - IDLE: a synchronised 0 starts the bit counter.
  - START: at CLKS_PER_BIT/2 cycles the line is re-sampled. If it is 1, this is a false start: return to IDLE with no pulse.
  - DATA: each data bit is sampled at its centre, CLKS_PER_BIT after the previous sample.
  - STOP, stop bit sampled 1: recv_pattern updates and recv_valid pulses for 1 cycle on the next edge; return to IDLE.
  - STOP, stop bit sampled 0: recv_frame_err pulses for 1 cycle; recv_pattern keeps its old value; go to WAIT_HIGH.
  - WAIT_HIGH: go to IDLE once the line is sampled 1.
  - Back-to-back frames with no idle gap are received correctly.
- RX and TX are fully independent and may operate simultaneously; a loopback of ser_tx to ser_rx is legal.
- Counters are sized to hold CLKS_PER_BIT-1 and never wrap inside a bit.

Optional Feature:
- Macro UART_PARITY_EN.
- When defined:
  - An even-parity bit is inserted between data bit 7 and the stop bit; frame is 11 bits.
  - RX checks the parity bit. On mismatch it pulses recv_frame_err, does not update recv_pattern, and does not pulse recv_valid.
- When undefined: plain 8N1 with no parity logic.

Test Plan (CLKS_PER_BIT=16):
- TX timing: tx_data=0x3D and tx_start=1 held → tx_busy=1 next cycle. ser_tx shows 0, then bits 1,0,1,1,1,1,0,0, then 1, each 16 cycles wide. tx_busy=0 and tx_clear_req=1 after 160 cycles. Hold tx_start 5 more cycles → no new frame.
- Handshake rearm: after the first frame, drop tx_start → tx_clear_req=0 next cycle. Send 0x0F → second frame carries 0x0F.
- RX good frame: drive 0x0F as an 8N1 waveform on ser_rx → recv_valid single pulse; recv_pattern=0x0F. Then drive 0x3D → recv_pattern=0x3D (61).
- RX errors: drive a 4-cycle low glitch → no pulse. Drive 0xA5 with stop bit 0 → recv_frame_err pulses; recv_pattern unchanged.
- Loopback: ser_tx tied to ser_rx; send 0x00, 0xFF, 0x55 back-to-back → recv_pattern sequence 0x00, 0xFF, 0x55.
- Reset mid-frame: assert reset during DATA → ser_tx=1 and tx_busy=0 immediately. After release, the next tx_start sends a full correct frame.
